// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory request, small fetched-instruction queue, redirect and discard handling.
// Optional feature: define IFETCH_EBREAK_HALT_EN to stop fetching after an EBREAK word is fetched.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
`ifdef IFETCH_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1
`ifdef IFETCH_EBREAK_HALT_EN
        ,
        HALTED = 2'd2
`endif
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   target;
    logic          discard;
    logic          req_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   q_word [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];

    logic        ack;
    logic        enq;
    logic        deq;
    logic        room_next;
    logic [31:0] redirect_target;
    logic        unused_low_bits;

    assign ack             = req_q & imem_ack;
    assign enq             = ack & ~discard & ~redirect_valid;
    assign deq             = inst_valid & inst_ready & ~redirect_valid;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    always_comb begin
        count_next = count;
        if (redirect_valid)
            count_next = '0;
        else if (enq && !deq)
            count_next = count + CW'(1);
        else if (deq && !enq)
            count_next = count - CW'(1);
    end

    assign room_next = (count_next < DEPTH_C);

    // imem_req is registered: it is decided one edge ahead from the next queue occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            target  <= RESET_PC;
            discard <= 1'b0;
            req_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            count <= count_next;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + PW'(1);
                if (deq)
                    rd_ptr <= rd_ptr + PW'(1);
            end

            if (redirect_valid) begin
                if (req_q && !imem_ack) begin
                    // Request must stay on the bus until acked; its response gets dropped.
                    state   <= WAIT;
                    req_q   <= 1'b1;
                    discard <= 1'b1;
                    target  <= redirect_target;
                end else begin
                    state   <= FETCH;
                    pc      <= redirect_target;
                    discard <= 1'b0;
                    req_q   <= 1'b1;
                end
            end else if (ack) begin
                if (discard) begin
                    pc      <= target;
                    discard <= 1'b0;
                    state   <= FETCH;
                    req_q   <= room_next;
                end else begin
                    pc <= pc + 32'd4;
`ifdef IFETCH_EBREAK_HALT_EN
                    if (imem_rdata == EBREAK) begin
                        state <= HALTED;
                        req_q <= 1'b0;
                    end else begin
                        state <= FETCH;
                        req_q <= room_next;
                    end
`else
                    state <= FETCH;
                    req_q <= room_next;
`endif
                end
            end else if (req_q) begin
                state <= WAIT;
                req_q <= 1'b1;
            end else if (state == FETCH) begin
                req_q <= room_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_word[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= pc;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    assign inst_word  = q_word[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

`ifdef IFETCH_EBREAK_HALT_EN
    assign halted = (state == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory responder, scoreboard of fetched words, directed sequences.
// Exercises the EBREAK halt path when IFETCH_EBREAK_HALT_EN is defined.
module tb_instruction_fetch;

    localparam logic [31:0] EBREAK_W = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        halted;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst_word2;
    logic [31:0] inst_pc2;
    logic        halted2;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word), .inst_pc(inst_pc),
        .halted(halted)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_word(inst_word2), .inst_pc(inst_pc2),
        .halted(halted2)
    );

    assign imem_ack2       = imem_req2;
    assign imem_rdata2     = 32'h0000_0013;
    assign redirect_valid2 = 1'b0;
    assign redirect_pc2    = 32'h0;
    assign inst_ready2     = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: condition not reached, required within bound", name);
    endtask

    // Memory responder
    int          ack_delay   = 0;
    int          wait_cnt    = 0;
    logic [31:0] ebreak_addr = 32'h0000_0001;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ebreak_addr)
            return EBREAK_W;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !imem_req) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Scoreboard: expected deliveries pushed on accepted acks, popped on inst handshakes
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_pc       = 32'h0;
    logic [31:0] exp_target   = 32'h0;
    logic        discard_pend = 1'b0;
    int          ack_count    = 0;
    logic        prev_pend    = 1'b0;
    logic [31:0] prev_addr    = 32'h0;
    logic [31:0] wrap_log [3];
    int          wrap_idx     = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_pc       = 32'h0;
            discard_pend = 1'b0;
            prev_pend    = 1'b0;
        end else begin
            if (prev_pend) begin
                check1("req_held", imem_req, 1'b1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deliver_unexpected: got pc %08h, required no delivery", inst_pc);
                end else begin
                    e = sb.pop_front();
                    check("deliver_pc", inst_pc, e.pc);
                    check("deliver_word", inst_word, e.word);
                end
            end
            if (imem_req && imem_ack) begin
                ack_count++;
                check("ack_addr", imem_addr, exp_pc);
            end
            if (redirect_valid) begin
                sb.delete();
                if (imem_req && !imem_ack) begin
                    discard_pend = 1'b1;
                    exp_target   = {redirect_pc[31:2], 2'b00};
                end else begin
                    discard_pend = 1'b0;
                    exp_pc       = {redirect_pc[31:2], 2'b00};
                end
            end else if (imem_req && imem_ack) begin
                if (discard_pend) begin
                    discard_pend = 1'b0;
                    exp_pc       = exp_target;
                end else begin
                    e.pc   = exp_pc;
                    e.word = mem_word(exp_pc);
                    sb.push_back(e);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (imem_req2 && wrap_idx < 3) begin
                wrap_log[wrap_idx] = imem_addr2;
                wrap_idx++;
            end
        end
    end

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs [4];

    initial begin
        int guard;
        int ack0;
        logic [31:0] wrap_exp [3];

        vecs[0] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100};
        vecs[1] = '{rpc: 32'h1234_567F, exp_addr: 32'h1234_567C};
        vecs[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
        vecs[3] = '{rpc: 32'h0000_0008, exp_addr: 32'h0000_0008};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Reset state and streaming fetch
        repeat (3) @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", inst_valid, 1'b0);
        check1("rst_halted", halted, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        guard = 0;
        while (!inst_valid && guard < 20) begin @(negedge clk); guard++; end
        if (!inst_valid) timeout("first_valid");
        for (int k = 0; k < 6; k++) begin
            check1("stream_valid", inst_valid, 1'b1);
            check("stream_pc", inst_pc, 32'(4 * k));
            @(negedge clk);
        end
        if (wrap_idx != 3) timeout("wrap_fetches");
        else for (int k = 0; k < 3; k++) check("wrap_addr", wrap_log[k], wrap_exp[k]);

        // Stalled decoder: queue fills to two entries, request stops
        @(posedge clk); #1 rst_n = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        check1("rst2_req", imem_req, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        ack0 = ack_count;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) check1("full_no_req", imem_req, 1'b0);
        end
        check("full_acks", 32'(ack_count - ack0), 32'd2);
        check1("full_valid", inst_valid, 1'b1);
        check("full_head_pc", inst_pc, 32'h0);
        @(posedge clk); #1 inst_ready = 1'b1;
        @(negedge clk);
        check1("deq_cycle_req", imem_req, 1'b0);
        @(negedge clk);
        check1("after_deq_req", imem_req, 1'b1);
        check("after_deq_addr", imem_addr, 32'h8);

        // Redirect during a 3-cycle wait; reset abandons the ongoing request
        @(posedge clk); #1 ack_delay = 3; rst_n = 1'b0;
        @(negedge clk);
        check1("rst3_req", imem_req, 1'b0);
        check1("rst3_valid", inst_valid, 1'b0);
        check1("rst3_halted", halted, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(inst_valid && inst_pc == 32'h0) && guard < 40);
        if (!(inst_valid && inst_pc == 32'h0)) timeout("slow_pc0");
        @(posedge clk); #1 inst_ready = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(imem_req && imem_addr == 32'h8) && guard < 40);
        if (!(imem_req && imem_addr == 32'h8)) timeout("req_8");
        check1("pre_redir_valid", inst_valid, 1'b1);
        check("pre_redir_pc", inst_pc, 32'h4);
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check1("wait_req_kept", imem_req, 1'b1);
        check("wait_addr_kept", imem_addr, 32'h8);
        check1("flush_valid", inst_valid, 1'b0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(imem_req && imem_addr != 32'h8) && guard < 20);
        check("redir_addr", imem_addr, 32'h0000_0100);
        @(posedge clk); #1 inst_ready = 1'b1;

        // Two redirects while a dropped response is still pending
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(imem_req && imem_addr == 32'h108) && guard < 60);
        if (!(imem_req && imem_addr == 32'h108)) timeout("req_108");
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        @(posedge clk); #1 redirect_pc = 32'h0000_0401;
        @(posedge clk); #1 redirect_valid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(imem_req && imem_addr != 32'h108) && guard < 20);
        check("double_redir_addr", imem_addr, 32'h0000_0400);

        // Redirect coinciding with an ack and an inst handshake
        @(posedge clk); #1 ack_delay = 0;
        repeat (8) @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check1("ack_redir_req", imem_req, 1'b1);
        check("ack_redir_addr", imem_addr, 32'h0000_0200);
        check1("ack_redir_flush", inst_valid, 1'b0);
        repeat (6) @(negedge clk);

        // Table of redirect targets applied to a full, idle queue
        @(posedge clk); #1 inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = vecs[v].rpc;
            @(posedge clk); #1 redirect_valid = 1'b0;
            @(negedge clk);
            check1("tbl_req", imem_req, 1'b1);
            check("tbl_addr", imem_addr, vecs[v].exp_addr);
            check1("tbl_flush", inst_valid, 1'b0);
            @(negedge clk);
            check1("tbl_valid", inst_valid, 1'b1);
            check("tbl_head_pc", inst_pc, vecs[v].exp_addr);
            check("tbl_head_word", inst_word, mem_word(vecs[v].exp_addr));
            repeat (4) @(negedge clk);
        end

        // EBREAK at pc 12
        @(posedge clk); #1 rst_n = 1'b0; inst_ready = 1'b1; ebreak_addr = 32'hC;
        @(posedge clk); #1 rst_n = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(inst_valid && inst_pc == 32'hC) && guard < 30);
        if (!(inst_valid && inst_pc == 32'hC)) timeout("ebreak_pc");
        check("ebreak_word", inst_word, EBREAK_W);
`ifdef IFETCH_EBREAK_HALT_EN
        check1("halt_set", halted, 1'b1);
        check1("halt_no_req", imem_req, 1'b0);
        repeat (4) @(negedge clk);
        check1("halt_still", halted, 1'b1);
        check1("halt_still_no_req", imem_req, 1'b0);
        check1("halt_drained", inst_valid, 1'b0);
        @(posedge clk); #1 ebreak_addr = 32'h1; redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check1("resume_halted", halted, 1'b0);
        check1("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h0);
        repeat (6) @(negedge clk);
`else
        check1("no_halt", halted, 1'b0);
        check1("no_halt_req", imem_req, 1'b1);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(inst_valid && inst_pc == 32'h10) && guard < 20);
        if (!(inst_valid && inst_pc == 32'h10)) timeout("past_ebreak");
        check1("no_halt_later", halted, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter QUEUE_DEPTH, default 2, fetched-instruction queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  byte address of the request; bits [1:0] always zero.
REQ-007 imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  raw instruction word.
REQ-009 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as zero.
REQ-011 inst_valid  output  1  queue head is valid for the decoder.
REQ-012 inst_ready  input  1  decoder consumes the head in this cycle.
REQ-013 inst_word  output  32  raw instruction at the queue head.
REQ-014 inst_pc  output  32  address of inst_word.
REQ-015 halted  output  1  fetch has stopped after EBREAK.

Function
REQ-016 The FSM SHALL have three states: FETCH (may raise a request), WAIT (request outstanding) and HALTED.
REQ-017 At most one request SHALL be outstanding at any time.
REQ-018 In FETCH, imem_req SHALL assert only when the number of queue entries is less than QUEUE_DEPTH; an ack in the same cycle completes the request without entering WAIT.
REQ-019 Once asserted, imem_req and imem_addr SHALL stay stable until the cycle of imem_ack.
REQ-020 On ack, {imem_rdata, imem_addr} SHALL be enqueued, the fetch pc SHALL advance by 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), and the state SHALL return to FETCH.
REQ-021 Fetch latency: an ack in cycle N SHALL make the word visible on inst_valid/inst_word in cycle N+1.
REQ-022 A dequeue SHALL occur when inst_valid && inst_ready; an enqueue and a dequeue in the same cycle SHALL both take effect, and the count SHALL be unchanged.
REQ-023 inst_valid SHALL equal "queue not empty"; inst_word and inst_pc are don't-care while inst_valid is 0.
REQ-024 A redirect SHALL flush the queue, set the fetch pc to {redirect_pc[31:2], 2'b00}, and leave HALTED if the block is halted.
REQ-025 A redirect in WAIT SHALL keep imem_req asserted until ack, discard that response, and then fetch from the new pc.
REQ-026 A redirect in the same cycle as an ack SHALL discard the acked data and SHALL NOT advance the pc by 4.
REQ-027 A redirect in the same cycle as an inst handshake SHALL take precedence; the consumed entry counts as delivered.
REQ-028 A redirect arriving while a discarded response is still pending SHALL update the target pc only.

Reset
REQ-029 While rst_n is low, the block SHALL be in FETCH with pc=RESET_PC, the queue empty, no discard pending, and imem_req=0, inst_valid=0, halted=0.
REQ-030 Assertion of rst_n mid-request SHALL abandon the request; the memory responder is reset by the same signal.
REQ-031 The first imem_req SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.

Configuration
REQ-032 With IFETCH_EBREAK_HALT_EN defined, an acked word equal to 32'h0010_0073 SHALL be enqueued and the state SHALL go to HALTED; no further requests are issued, halted=1 from the next cycle, and the queue still drains normally.
REQ-033 With IFETCH_EBREAK_HALT_EN undefined, EBREAK SHALL be fetched like any other word, the HALTED state SHALL be absent, and halted SHALL be tied to 0.

Verification
REQ-034 Reset release, memory acks in the same cycle, inst_ready=1 -> inst_pc sequence 0,4,8,12 and one instruction per cycle after the first.
REQ-035 inst_ready=0 for 10 cycles with QUEUE_DEPTH=2 -> exactly 2 entries (pc 0,4), then imem_req=0 until a dequeue occurs.
REQ-036 Redirect to 32'h0000_0103 while a request to 8 is in WAIT with a 3-cycle ack -> the response for 8 is dropped, the next imem_addr is 32'h0000_0100, and the queue is empty after the redirect.
REQ-037 Word 32'h0010_0073 at pc 12 with the macro defined -> EBREAK is delivered with inst_pc=12, halted=1, no further imem_req; a redirect to 0 resumes fetch at 0 with halted=0.
REQ-038 RESET_PC=32'hFFFF_FFF8, fetches run continuously -> imem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
